// File: rtl/mm_ram_arbiter.sv
// Two-requester arbiter for the 512x32 result SRAM: MAC result writes vs host reads.
// Optional MM_ARB_STATS_EN adds saturating grant and stall counters.
module mm_ram_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int WR_W     = 18,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WR_W-1:0]   wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_men,
  output logic              ram_wen,
  output logic              ram_ren,
  input  logic [DATA_W-1:0] ram_dout,
`ifdef MM_ARB_STATS_EN
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       stall_cnt,
`endif
  output logic              busy
);

  localparam logic [3:0] MAXW = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;
  logic       rd_pend;
  logic       rd_sat;

  assign rd_sat = rd_req && (wait_cnt == MAXW);
  // Grants are gated by rst_n so nothing reaches the SRAM while in reset
  assign rd_gnt = rst_n & rd_req & (~wr_req | rd_sat);
  assign wr_gnt = rst_n & wr_req & ~rd_sat;
  assign busy   = rd_req | wr_req | rd_pend;

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_men  = 1'b0;
    ram_wen  = 1'b0;
    ram_ren  = 1'b0;
    unique case (1'b1)
      wr_gnt: begin
        ram_men  = 1'b1;
        ram_wen  = 1'b1;
        ram_addr = wr_addr;
        ram_din  = {{(DATA_W-WR_W){1'b0}}, wr_data};
      end
      rd_gnt: begin
        ram_men  = 1'b1;
        ram_ren  = 1'b1;
        ram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (!rd_req || rd_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != MAXW)
        wait_cnt <= wait_cnt + 4'd1;
      rd_pend  <= rd_gnt;
      rd_valid <= rd_pend;
      if (rd_pend)
        rd_data <= ram_dout;
    end
  end

`ifdef MM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (wr_gnt && wr_cnt != 16'hFFFF)
        wr_cnt <= wr_cnt + 16'd1;
      if (rd_gnt && rd_cnt != 16'hFFFF)
        rd_cnt <= rd_cnt + 16'd1;
      if (rd_req && !rd_gnt && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_ram_arbiter.sv
// Bench for mm_ram_arbiter: SRAM model, read-data scoreboard, per-scenario tasks.
// Define MM_ARB_STATS_EN to also exercise the statistics counters.
module tb_mm_ram_arbiter;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_req, rd_req;
  logic [8:0]  wr_addr, rd_addr;
  logic [17:0] wr_data;
  logic        wr_gnt, rd_gnt, rd_valid;
  logic [31:0] rd_data;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_men, ram_wen, ram_ren, busy;
`ifdef MM_ARB_STATS_EN
  logic [15:0] wr_cnt, rd_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[512];
  logic [31:0] shadow[512];

  always #5 clk = ~clk;

  mm_ram_arbiter #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_men(ram_men),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_dout(ram_dout),
`ifdef MM_ARB_STATS_EN
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  // Single-port SRAM with one-cycle read latency
  always @(posedge clk) begin
    if (ram_men) begin
      if (ram_wen) mem[ram_addr] <= ram_din;
      if (ram_ren) ram_dout <= mem[ram_addr];
    end
  end

  // Scoreboard: every completed read must match the oldest expected word
  always @(posedge clk) begin
    #1;
    if (rst_n && rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_valid data %h, expected no read", rd_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_req = 1'b1; rd_req = 1'b1;
    wr_addr = 9'd1; rd_addr = 9'd2; wr_data = 18'h1;
    @(negedge clk);
    checks++;
    if ({wr_gnt, rd_gnt, ram_men, ram_wen, ram_ren} !== 5'b0) begin
      errors++;
      $display("FAIL reset_gnt: got %b expected 00000",
               {wr_gnt, rd_gnt, ram_men, ram_wen, ram_ren});
    end
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd: got valid %b data %h expected 0 0", rd_valid, rd_data);
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int got;
    wr_req = 1'b1; wr_addr = 9'd5; wr_data = 18'h3FFFF;
    @(negedge clk);
    checks++;
    if (!(wr_gnt === 1'b1 && rd_gnt === 1'b0 && ram_men === 1'b1 &&
          ram_wen === 1'b1 && ram_ren === 1'b0)) begin
      errors++;
      $display("FAIL wr_grant: got gnt %b men/wen/ren %b%b%b expected 1 110",
               wr_gnt, ram_men, ram_wen, ram_ren);
    end
    checks++;
    if (ram_din !== 32'h0003_FFFF || ram_addr !== 9'd5) begin
      errors++;
      $display("FAIL wr_bus: got din %h addr %0d expected 0003ffff 5", ram_din, ram_addr);
    end
    tick();
    shadow[5] = 32'h0003_FFFF;
    wr_req = 1'b0;
    rd_req = 1'b1; rd_addr = 9'd5;
    exp_q.push_back(shadow[5]);
    @(negedge clk);
    checks++;
    if (!(rd_gnt === 1'b1 && ram_ren === 1'b1 && ram_wen === 1'b0 &&
          ram_din === 32'h0 && ram_addr === 9'd5)) begin
      errors++;
      $display("FAIL rd_grant: got gnt %b ren %b din %h addr %0d expected 1 1 0 5",
               rd_gnt, ram_ren, ram_din, ram_addr);
    end
    tick();
    rd_req = 1'b0;
    got = 0;
    for (int i = 0; i < 3 && got == 0; i++) begin
      tick();
      if (rd_valid === 1'b1) got = 1;
    end
    checks++;
    if (got != 1 || rd_data !== 32'h0003_FFFF) begin
      errors++;
      $display("FAIL wr_then_rd: got valid %0d data %h expected 1 0003ffff", got, rd_data);
    end
    repeat (2) tick();
  endtask

  task automatic test_starvation();
    int mw, run, maxrun, nrd;
    logic exp_r;
    mw = 0; run = 0; maxrun = 0; nrd = 0;
    wr_req = 1'b1; wr_addr = 9'd21; wr_data = 18'd1;
    rd_req = 1'b1; rd_addr = 9'd20;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      exp_r = (mw == MAXW);
      checks++;
      if (rd_gnt !== exp_r || wr_gnt !== !exp_r) begin
        errors++;
        $display("FAIL starve_c%0d: got rd/wr %b%b expected %b%b",
                 c, rd_gnt, wr_gnt, exp_r, !exp_r);
      end
      if (exp_r) begin
        exp_q.push_back(shadow[20]);
        mw = 0;
      end else begin
        shadow[21] = {14'h0, wr_data};
        mw = (mw < MAXW) ? mw + 1 : MAXW;
      end
      if (rd_gnt === 1'b1) begin
        nrd++;
        run = 0;
      end else begin
        run++;
        if (run > maxrun) maxrun = run;
      end
      tick();
      wr_data = wr_data + 18'd3;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    checks++;
    if (nrd != 3 || maxrun > MAXW) begin
      errors++;
      $display("FAIL starve_bound: got reads %0d maxwait %0d expected 3 <=%0d",
               nrd, maxrun, MAXW);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] v;
    int ones, rises;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1; rd_addr = 9'(i);
      exp_q.push_back(shadow[i]);
      @(negedge clk);
      checks++;
      if (rd_gnt !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gnt%0d: got %b expected 1", i, rd_gnt);
      end
      tick();
      v[i] = rd_valid;
    end
    rd_req = 1'b0;
    for (int i = 3; i < 6; i++) begin
      tick();
      v[i] = rd_valid;
    end
    ones = 0; rises = 0;
    for (int i = 0; i < 6; i++) begin
      if (v[i]) ones++;
      if (v[i] && (i == 0 || !v[i-1])) rises++;
    end
    checks++;
    if (ones != 3 || rises != 1) begin
      errors++;
      $display("FAIL b2b_valid: got pattern %b expected 3 consecutive", v);
    end
  endtask

  task automatic test_drop();
    int first;
    wr_req = 1'b1; wr_addr = 9'd22; wr_data = 18'h2AAAA;
    rd_req = 1'b1; rd_addr = 9'd23;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rd_gnt !== 1'b0) begin
        errors++;
        $display("FAIL drop_wait%0d: got rd_gnt %b expected 0", i, rd_gnt);
      end
      tick();
    end
    shadow[22] = 32'h0002_AAAA;
    rd_req = 1'b0;
    tick();
    rd_req = 1'b1;
    exp_q.push_back(shadow[23]);
    first = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rd_gnt === 1'b1 && first < 0) first = i;
      tick();
      if (first >= 0) rd_req = 1'b0;
    end
    wr_req = 1'b0; rd_req = 1'b0;
    checks++;
    if (first != MAXW) begin
      errors++;
      $display("FAIL drop_clear: got first grant at %0d expected %0d", first, MAXW);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1'b1; rd_addr = 9'd7;
    @(negedge clk);
    checks++;
    if (rd_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt: got %b expected 1", rd_gnt);
    end
    tick();
    rd_req = 1'b0;
    wr_req = 1'b1; wr_addr = 9'd40; wr_data = 18'h5;
    rst_n = 1'b0;
    #2;
    checks++;
    if (wr_gnt !== 1'b0 || ram_men !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: got wr_gnt %b men %b valid %b expected 0 0 0",
               wr_gnt, ram_men, rd_valid);
    end
    wr_req = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
        errors++;
        $display("FAIL mid_discard%0d: got valid %b data %h expected 0 0",
                 i, rd_valid, rd_data);
      end
    end
  endtask

  task automatic test_busy();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_idle: got %b expected 0", busy);
    end
    tick();
    rd_req = 1'b1; rd_addr = 9'd9;
    exp_q.push_back(shadow[9]);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_req: got %b expected 1", busy);
    end
    tick();
    rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_pend: got %b expected 1", busy);
    end
    repeat (3) tick();
  endtask

`ifdef MM_ARB_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    wr_req = 1'b1; wr_addr = 9'd31;
    for (int i = 0; i < 8; i++) begin
      wr_data = 18'(i + 100);
      tick();
      shadow[31] = 32'(i + 100);
    end
    rd_req = 1'b1; rd_addr = 9'd30;
    exp_q.push_back(shadow[30]);
    for (int i = 0; i < 2; i++) begin
      wr_data = 18'(i + 200);
      tick();
      shadow[31] = 32'(i + 200);
    end
    wr_req = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      rd_addr = 9'(32 + i);
      exp_q.push_back(shadow[32 + i]);
      tick();
    end
    rd_req = 1'b0;
    repeat (4) tick();
    checks++;
    if (wr_cnt !== 16'd10 || rd_cnt !== 16'd3 || stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stats: got wr %0d rd %0d stall %0d expected 10 3 2",
               wr_cnt, rd_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]    = 32'hA500_0000 | 32'(i);
      shadow[i] = 32'hA500_0000 | 32'(i);
    end
    test_reset();
    test_write_read();
    test_starvation();
    test_back_to_back();
    test_drop();
    test_reset_mid_read();
    test_busy();
`ifdef MM_ARB_STATS_EN
    test_stats();
`endif
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d reads outstanding expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
